dfdd_frame_ctrl: RTL and testbench
==================================

DFDD_FRAME_CTRL -- requirements
Module: dfdd_frame_ctrl

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8: exponent width of the datapath floating-point format.
REQ-002 SHALL have parameter FRAC_WIDTH, default 23: fraction width of the datapath floating-point format.
REQ-003 SHALL have parameter SCALES, default 3: number of filter scales.
REQ-004 SHALL have parameter DRAIN_TIMEOUT, default 4096: maximum number of DRAIN cycles.
REQ-005 SHALL have local parameters FP_WIDTH_REG = 1+EXP_WIDTH+FRAC_WIDTH and NCOEF = 4*SCALES+1.
REQ-006 SHALL provide the following ports, listed as name, direction, width, meaning:
- clk_i  in  1  the single clock; synchronous, active-high reset is already decided.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  frame start pulse.
- abort_i  in  1  frame abort pulse.
- frame_width_i, frame_height_i  in  16 each  frame dimensions; sampled only at start.
- pix_valid_i  in  1 / pix_ready_o  out  1  upstream pixel handshake.
- dp_valid_o  out  1, dp_col_o  out  16, dp_row_o  out  16  drive the datapath valid_i, col_i and row_i.
- dp_valid_i  in  1, dp_col_i  in  16, dp_row_i  in  16  observe the datapath valid_o, col_o and row_o.
- cfg_we_i  in  1, cfg_addr_i  in  $clog2(NCOEF), cfg_data_i  in  FP_WIDTH_REG  coefficient write port.
- cfg_commit_i  in  1  request copy of shadow bank to active bank.
- w_o  out  FP_WIDTH_REG x [SCALES][3], w_t_o  out  FP_WIDTH_REG, a_o  out  FP_WIDTH_REG x [SCALES]  active coefficients.
- busy_o, commit_pending_o  out  1 each  status.
- frame_done_o, timeout_o  out  1 each  single-cycle pulses.

Function
REQ-007 SHALL implement states IDLE, RUN and DRAIN.
REQ-008 In IDLE, start_i with both dimensions nonzero SHALL latch W and H, clear col/row, and enter RUN next cycle; start_i with either dimension zero SHALL be ignored.
REQ-009 pix_ready_o SHALL be 1 exactly in RUN; a pixel is accepted when pix_valid_i and pix_ready_o are both 1.
REQ-010 Each accepted pixel SHALL produce dp_valid_o=1 on the next cycle, with registered dp_col_o/dp_row_o equal to its raster position; otherwise dp_valid_o SHALL be 0 and col/row SHALL hold.
REQ-011 col SHALL increment per accepted pixel and wrap to 0 after W-1, when row increments.
REQ-012 Acceptance at (W-1, H-1) SHALL move the state to DRAIN.
REQ-013 In DRAIN, dp_valid_i with dp_col_i=W-1 and dp_row_i=H-1 SHALL pulse frame_done_o for one cycle and return to IDLE.
REQ-014 DRAIN SHALL count cycles; reaching DRAIN_TIMEOUT cycles SHALL pulse timeout_o and return to IDLE with no frame_done_o.
REQ-015 abort_i SHALL, from any state, return to IDLE on the next cycle, clear counters and deassert pix_ready_o, with no frame_done_o; abort_i SHALL dominate start_i.
REQ-016 busy_o SHALL equal (state != IDLE).
REQ-017 cfg_we_i SHALL write the shadow bank in any state: addr s*3+k maps to w[s][k], 3*SCALES maps to w_t, and 3*SCALES+1+s maps to a[s].
REQ-018 Writes to addresses >= NCOEF SHALL be ignored.
REQ-019 cfg_commit_i SHALL set a pending flag, visible as commit_pending_o.
REQ-020 The shadow-to-active copy SHALL occur only in a cycle where the state is IDLE, then clear the flag; active outputs SHALL never change while busy_o=1.
REQ-021 A commit in the same cycle as cfg_we_i SHALL copy the pre-write shadow contents.
REQ-022 A commit in the same IDLE cycle as start_i SHALL apply before the frame, so the frame uses the new bank.
REQ-023 The transition into IDLE from DRAIN or abort SHALL apply a pending commit on the first IDLE cycle.

Reset
REQ-024 rst_i SHALL force: state IDLE, all counters 0, shadow and active banks 0, pending flag 0, and every output 0.
REQ-025 rst_i SHALL take precedence over every other input, including mid-frame.

Structure
REQ-026 Package dfdd_ctrl_pkg SHALL hold the state enum and the coefficient address-offset constants/functions.
REQ-027 Sub-module dfdd_coef_bank SHALL hold the shadow/active register pair, write decode and commit copy.
REQ-028 The FSM and raster counters SHALL reside in dfdd_frame_ctrl.

Verification
REQ-029 Frame scenario: W=4, H=2, pix_valid_i held 1 -> dp_valid_o for 8 cycles with (col,row) = (0,0)..(3,0),(0,1)..(3,1); DRAIN; echoed (3,1) -> one frame_done_o pulse, then IDLE.
REQ-030 Backpressure/gaps scenario: pix_valid_i toggling 1,0,1,0 on a W=3, H=1 frame -> coordinates 0,1,2 without skips, dp_valid_o only on accepted pixels.
REQ-031 Commit scenario: write w[1][2]=0x3F800000, then commit during RUN -> w_o unchanged and commit_pending_o=1 until frame_done_o; new value visible on the first IDLE cycle.
REQ-032 Timeout scenario: DRAIN_TIMEOUT=16 with no echoed last pixel -> timeout_o after 16 DRAIN cycles and no frame_done_o.
REQ-033 Abort scenario: abort_i at pixel 5 of a 4x4 frame -> IDLE next cycle, pix_ready_o=0; a new start_i then begins at (0,0).
REQ-034 Zero-size and reset scenario: start_i with W=0 stays in IDLE; rst_i mid-RUN zeroes all outputs and both banks.

Source files
------------

// File: rtl/dfdd_ctrl_pkg.sv
// Shared types and coefficient address map for the DFDD frame controller.
// Address layout per bank: w[s][k] at 3*s+k, then w_t, then a[s].
package dfdd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int COEF_PER_SCALE = 3;

    function automatic int coef_w_addr(input int s, input int k);
        return COEF_PER_SCALE * s + k;
    endfunction

    function automatic int coef_wt_addr(input int scales);
        return COEF_PER_SCALE * scales;
    endfunction

    function automatic int coef_a_addr(input int scales, input int s);
        return COEF_PER_SCALE * scales + 1 + s;
    endfunction

    function automatic int coef_count(input int scales);
        return (COEF_PER_SCALE + 1) * scales + 1;
    endfunction

endpackage

// File: rtl/dfdd_coef_bank.sv
// Shadow/active coefficient register pair. Writes land in the shadow bank;
// a commit copies shadow to active only when the controller allows it.
module dfdd_coef_bank
    import dfdd_ctrl_pkg::*;
#(
    parameter  int EXP_WIDTH    = 8,
    parameter  int FRAC_WIDTH   = 23,
    parameter  int SCALES       = 3,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
    localparam int NCOEF        = coef_count(SCALES),
    localparam int AW           = $clog2(NCOEF)
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       we_i,
    input  logic [AW-1:0]                              addr_i,
    input  logic [FP_WIDTH_REG-1:0]                    data_i,
    input  logic                                       commit_i,
    input  logic                                       apply_ok_i,
    output logic [SCALES-1:0][2:0][FP_WIDTH_REG-1:0]   w_o,
    output logic [FP_WIDTH_REG-1:0]                    w_t_o,
    output logic [SCALES-1:0][FP_WIDTH_REG-1:0]        a_o,
    output logic                                       commit_pending_o
);

    logic [SCALES-1:0][2:0][FP_WIDTH_REG-1:0] r_w_sh;
    logic [SCALES-1:0][2:0][FP_WIDTH_REG-1:0] r_w_act;
    logic [FP_WIDTH_REG-1:0]                  r_wt_sh;
    logic [FP_WIDTH_REG-1:0]                  r_wt_act;
    logic [SCALES-1:0][FP_WIDTH_REG-1:0]      r_a_sh;
    logic [SCALES-1:0][FP_WIDTH_REG-1:0]      r_a_act;
    logic                                     r_pending;

    logic w_req;
    logic w_apply;

    assign w_req   = r_pending | commit_i;
    assign w_apply = w_req & apply_ok_i;

    // NOTE: both banks are explicit registers with a reset, not a RAM, because
    // the reset state of every coefficient must be observable as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_w_sh    <= '0;
            r_w_act   <= '0;
            r_wt_sh   <= '0;
            r_wt_act  <= '0;
            r_a_sh    <= '0;
            r_a_act   <= '0;
            r_pending <= 1'b0;
        end else begin
            // Copy reads the shadow values from before this cycle's write.
            if (w_apply) begin
                r_w_act  <= r_w_sh;
                r_wt_act <= r_wt_sh;
                r_a_act  <= r_a_sh;
            end
            if (we_i) begin
                for (int s = 0; s < SCALES; s++) begin
                    for (int k = 0; k < COEF_PER_SCALE; k++) begin
                        if (int'(addr_i) == coef_w_addr(s, k)) r_w_sh[s][k] <= data_i;
                    end
                    if (int'(addr_i) == coef_a_addr(SCALES, s)) r_a_sh[s] <= data_i;
                end
                if (int'(addr_i) == coef_wt_addr(SCALES)) r_wt_sh <= data_i;
            end
            r_pending <= w_req & ~apply_ok_i;
        end
    end

    assign w_o              = r_w_act;
    assign w_t_o            = r_wt_act;
    assign a_o              = r_a_act;
    assign commit_pending_o = r_pending;

endmodule

// File: rtl/dfdd_frame_ctrl.sv
// Frame sequencer for the DFDD datapath: raster counters, drain/echo tracking
// with timeout, and gating of coefficient commits to idle periods.
module dfdd_frame_ctrl
    import dfdd_ctrl_pkg::*;
#(
    parameter  int EXP_WIDTH     = 8,
    parameter  int FRAC_WIDTH    = 23,
    parameter  int SCALES        = 3,
    parameter  int DRAIN_TIMEOUT = 4096,
    localparam int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH,
    localparam int NCOEF         = 4 * SCALES + 1,
    localparam int AW            = $clog2(NCOEF)
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       start_i,
    input  logic                                       abort_i,
    input  logic [15:0]                                frame_width_i,
    input  logic [15:0]                                frame_height_i,
    input  logic                                       pix_valid_i,
    output logic                                       pix_ready_o,
    output logic                                       dp_valid_o,
    output logic [15:0]                                dp_col_o,
    output logic [15:0]                                dp_row_o,
    input  logic                                       dp_valid_i,
    input  logic [15:0]                                dp_col_i,
    input  logic [15:0]                                dp_row_i,
    input  logic                                       cfg_we_i,
    input  logic [AW-1:0]                              cfg_addr_i,
    input  logic [FP_WIDTH_REG-1:0]                    cfg_data_i,
    input  logic                                       cfg_commit_i,
    output logic [SCALES-1:0][2:0][FP_WIDTH_REG-1:0]   w_o,
    output logic [FP_WIDTH_REG-1:0]                    w_t_o,
    output logic [SCALES-1:0][FP_WIDTH_REG-1:0]        a_o,
    output logic                                       busy_o,
    output logic                                       commit_pending_o,
    output logic                                       frame_done_o,
    output logic                                       timeout_o
);

    localparam int             DCW        = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);

    state_t          r_state;
    logic [15:0]     r_w;
    logic [15:0]     r_h;
    logic [15:0]     r_col;
    logic [15:0]     r_row;
    logic [DCW-1:0]  r_drain_cnt;
    logic            r_dp_valid;
    logic [15:0]     r_dp_col;
    logic [15:0]     r_dp_row;
    logic            r_frame_done;
    logic            r_timeout;

    logic w_accept;
    logic w_col_last;
    logic w_row_last;
    logic w_echo_last;
    logic w_drain_end;
    logic w_to_idle;
    logic w_apply_ok;

    assign w_accept    = (r_state == ST_RUN) && pix_valid_i && !abort_i;
    assign w_col_last  = (r_col == r_w - 16'd1);
    assign w_row_last  = (r_row == r_h - 16'd1);
    assign w_echo_last = dp_valid_i && (dp_col_i == r_w - 16'd1) && (dp_row_i == r_h - 16'd1);
    assign w_drain_end = (r_drain_cnt == DRAIN_LAST);
    assign w_to_idle   = abort_i || ((r_state == ST_DRAIN) && (w_echo_last || w_drain_end));
    // Commits land while idle or on the edge that re-enters idle, so the first
    // idle cycle already shows the new bank and a busy frame never sees a change.
    assign w_apply_ok  = (r_state == ST_IDLE) || w_to_idle;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_w          <= '0;
            r_h          <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_drain_cnt  <= '0;
            r_dp_valid   <= 1'b0;
            r_dp_col     <= '0;
            r_dp_row     <= '0;
            r_frame_done <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_dp_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_timeout    <= 1'b0;
            if (abort_i) begin
                r_state     <= ST_IDLE;
                r_col       <= '0;
                r_row       <= '0;
                r_drain_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_i && (frame_width_i != 16'd0) && (frame_height_i != 16'd0)) begin
                            r_w     <= frame_width_i;
                            r_h     <= frame_height_i;
                            r_col   <= '0;
                            r_row   <= '0;
                            r_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (w_accept) begin
                            r_dp_valid <= 1'b1;
                            r_dp_col   <= r_col;
                            r_dp_row   <= r_row;
                            if (w_col_last) begin
                                r_col <= '0;
                                if (w_row_last) begin
                                    r_row       <= '0;
                                    r_drain_cnt <= '0;
                                    r_state     <= ST_DRAIN;
                                end else begin
                                    r_row <= r_row + 16'd1;
                                end
                            end else begin
                                r_col <= r_col + 16'd1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (w_echo_last) begin
                            r_frame_done <= 1'b1;
                            r_drain_cnt  <= '0;
                            r_state      <= ST_IDLE;
                        end else if (w_drain_end) begin
                            r_timeout   <= 1'b1;
                            r_drain_cnt <= '0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign pix_ready_o  = (r_state == ST_RUN);
    assign busy_o       = (r_state != ST_IDLE);
    assign dp_valid_o   = r_dp_valid;
    assign dp_col_o     = r_dp_col;
    assign dp_row_o     = r_dp_row;
    assign frame_done_o = r_frame_done;
    assign timeout_o    = r_timeout;

    dfdd_coef_bank #(
        .EXP_WIDTH  (EXP_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .SCALES     (SCALES)
    ) u_coef_bank (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .we_i             (cfg_we_i),
        .addr_i           (cfg_addr_i),
        .data_i           (cfg_data_i),
        .commit_i         (cfg_commit_i),
        .apply_ok_i       (w_apply_ok),
        .w_o              (w_o),
        .w_t_o            (w_t_o),
        .a_o              (a_o),
        .commit_pending_o (commit_pending_o)
    );

endmodule

// File: tb/tb_dfdd_frame_ctrl.sv
// Directed bench for dfdd_frame_ctrl: raster, gaps, commit gating, timeout,
// abort, zero-size start and mid-frame reset, with hand-computed expectations.
module tb_dfdd_frame_ctrl;

    localparam int SCALES = 3;
    localparam int FP     = 32;

    logic                            clk = 1'b0;
    logic                            rst = 1'b1;
    logic                            start = 1'b0;
    logic                            abort = 1'b0;
    logic [15:0]                     fw = '0;
    logic [15:0]                     fh = '0;
    logic                            pix_valid = 1'b0;
    logic                            pix_ready;
    logic                            dp_valid;
    logic [15:0]                     dp_col;
    logic [15:0]                     dp_row;
    logic                            echo_valid = 1'b0;
    logic [15:0]                     echo_col = '0;
    logic [15:0]                     echo_row = '0;
    logic                            cfg_we = 1'b0;
    logic [3:0]                      cfg_addr = '0;
    logic [FP-1:0]                   cfg_data = '0;
    logic                            cfg_commit = 1'b0;
    logic [SCALES-1:0][2:0][FP-1:0]  w_o;
    logic [FP-1:0]                   w_t_o;
    logic [SCALES-1:0][FP-1:0]       a_o;
    logic                            busy;
    logic                            pending;
    logic                            frame_done;
    logic                            timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dfdd_frame_ctrl #(
        .EXP_WIDTH     (8),
        .FRAC_WIDTH    (23),
        .SCALES        (SCALES),
        .DRAIN_TIMEOUT (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .abort_i          (abort),
        .frame_width_i    (fw),
        .frame_height_i   (fh),
        .pix_valid_i      (pix_valid),
        .pix_ready_o      (pix_ready),
        .dp_valid_o       (dp_valid),
        .dp_col_o         (dp_col),
        .dp_row_o         (dp_row),
        .dp_valid_i       (echo_valid),
        .dp_col_i         (echo_col),
        .dp_row_i         (echo_row),
        .cfg_we_i         (cfg_we),
        .cfg_addr_i       (cfg_addr),
        .cfg_data_i       (cfg_data),
        .cfg_commit_i     (cfg_commit),
        .w_o              (w_o),
        .w_t_o            (w_t_o),
        .a_o              (a_o),
        .busy_o           (busy),
        .commit_pending_o (pending),
        .frame_done_o     (frame_done),
        .timeout_o        (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic start_frame(input logic [15:0] w, input logic [15:0] h);
        fw    = w;
        fh    = h;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_ready",    32'(pix_ready), 32'd0);
        check("rst_dp_valid", 32'(dp_valid), 32'd0);
        check("rst_done",     32'(frame_done), 32'd0);
        check("rst_timeout",  32'(timeout), 32'd0);
        check("rst_pending",  32'(pending), 32'd0);
        check("rst_w_zero",   32'(w_o == '0), 32'd1);
        rst = 1'b0;
        tick();

        // 4x2 raster with continuous valid
        start_frame(16'd4, 16'd2);
        check("f1_busy",     32'(busy), 32'd1);
        check("f1_ready",    32'(pix_ready), 32'd1);
        check("f1_no_valid", 32'(dp_valid), 32'd0);
        pix_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("f1_valid", 32'(dp_valid), 32'd1);
            check("f1_col",   32'(dp_col), 32'(i % 4));
            check("f1_row",   32'(dp_row), 32'(i / 4));
        end
        pix_valid = 1'b0;
        check("f1_drain_ready", 32'(pix_ready), 32'd0);
        check("f1_drain_busy",  32'(busy), 32'd1);
        echo_valid = 1'b1; echo_col = 16'd2; echo_row = 16'd1;
        tick();
        check("f1_dp_idle",     32'(dp_valid), 32'd0);
        check("f1_wrong_echo",  32'(frame_done), 32'd0);
        echo_col = 16'd3;
        tick();
        echo_valid = 1'b0;
        check("f1_done",        32'(frame_done), 32'd1);
        check("f1_idle",        32'(busy), 32'd0);
        tick();
        check("f1_done_pulse",  32'(frame_done), 32'd0);

        // 3x1 frame with gaps in pix_valid
        start_frame(16'd3, 16'd1);
        pix_valid = 1'b1; tick();
        check("g_v0",   32'(dp_valid), 32'd1);
        check("g_c0",   32'(dp_col), 32'd0);
        pix_valid = 1'b0; tick();
        check("g_gap0", 32'(dp_valid), 32'd0);
        check("g_hold", 32'(dp_col), 32'd0);
        pix_valid = 1'b1; tick();
        check("g_v1",   32'(dp_valid), 32'd1);
        check("g_c1",   32'(dp_col), 32'd1);
        pix_valid = 1'b0; tick();
        check("g_gap1", 32'(dp_valid), 32'd0);
        pix_valid = 1'b1; tick();
        pix_valid = 1'b0;
        check("g_v2",    32'(dp_valid), 32'd1);
        check("g_c2",    32'(dp_col), 32'd2);
        check("g_r2",    32'(dp_row), 32'd0);
        check("g_drain", 32'(pix_ready), 32'd0);
        echo_valid = 1'b1; echo_col = 16'd2; echo_row = 16'd0;
        tick();
        echo_valid = 1'b0;
        check("g_done",  32'(frame_done), 32'd1);

        // Commit requested mid-frame waits for idle
        cfg_write(4'd5, 32'h3F80_0000);
        cfg_write(4'd10, 32'h4000_0000);
        cfg_write(4'd13, 32'hFFFF_FFFF);
        check("c_shadow_only", w_o[1][2], 32'h0);
        start_frame(16'd2, 16'd1);
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        check("c_pending_run", 32'(pending), 32'd1);
        check("c_w_hold_run",  w_o[1][2], 32'h0);
        pix_valid = 1'b1; tick(); tick(); pix_valid = 1'b0;
        check("c_busy_drain",    32'(busy), 32'd1);
        check("c_pending_drain", 32'(pending), 32'd1);
        check("c_w_hold_drain",  w_o[1][2], 32'h0);
        echo_valid = 1'b1; echo_col = 16'd1; echo_row = 16'd0;
        tick();
        echo_valid = 1'b0;
        check("c_done",        32'(frame_done), 32'd1);
        check("c_w_new",       w_o[1][2], 32'h3F80_0000);
        check("c_a0_new",      a_o[0], 32'h4000_0000);
        check("c_a2_ignored",  a_o[2], 32'h0);
        check("c_pending_clr", 32'(pending), 32'd0);

        // Commit with simultaneous write copies the pre-write shadow
        cfg_commit = 1'b1;
        cfg_write(4'd9, 32'h1111_1111);
        cfg_commit = 1'b0;
        check("cw_prewrite", w_t_o, 32'h0);
        check("cw_pending",  32'(pending), 32'd0);
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        check("cw_second",   w_t_o, 32'h1111_1111);

        // Commit with start applies before the frame; then drain timeout
        cfg_write(4'd0, 32'hAAAA_5555);
        cfg_commit = 1'b1;
        start_frame(16'd1, 16'd1);
        cfg_commit = 1'b0;
        check("cs_busy",    32'(busy), 32'd1);
        check("cs_w00",     w_o[0][0], 32'hAAAA_5555);
        check("cs_pending", 32'(pending), 32'd0);
        pix_valid = 1'b1; tick(); pix_valid = 1'b0;
        check("t_valid", 32'(dp_valid), 32'd1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("t_wait_to", 32'(timeout), 32'd0);
            check("t_wait_bz", 32'(busy), 32'd1);
        end
        tick();
        check("t_timeout", 32'(timeout), 32'd1);
        check("t_no_done", 32'(frame_done), 32'd0);
        check("t_idle",    32'(busy), 32'd0);
        tick();
        check("t_pulse",   32'(timeout), 32'd0);

        // Abort at pixel 5 of a 4x4 frame
        start_frame(16'd4, 16'd4);
        pix_valid = 1'b1;
        repeat (5) tick();
        check("ab_col", 32'(dp_col), 32'd0);
        check("ab_row", 32'(dp_row), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        pix_valid = 1'b0;
        check("ab_idle",    32'(busy), 32'd0);
        check("ab_ready",   32'(pix_ready), 32'd0);
        check("ab_novalid", 32'(dp_valid), 32'd0);
        check("ab_nodone",  32'(frame_done), 32'd0);
        abort = 1'b1;
        start_frame(16'd4, 16'd4);
        abort = 1'b0;
        check("ab_dominates", 32'(busy), 32'd0);
        start_frame(16'd4, 16'd4);
        check("ab_restart", 32'(busy), 32'd1);
        pix_valid = 1'b1; tick();
        check("ab_new_c0", 32'(dp_col), 32'd0);
        check("ab_new_r0", 32'(dp_row), 32'd0);
        tick();
        check("ab_new_c1", 32'(dp_col), 32'd1);

        // Reset mid-frame with a pending commit
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        check("rs_pending_pre", 32'(pending), 32'd1);
        rst = 1'b1; tick();
        pix_valid = 1'b0;
        check("rs_busy",    32'(busy), 32'd0);
        check("rs_ready",   32'(pix_ready), 32'd0);
        check("rs_valid",   32'(dp_valid), 32'd0);
        check("rs_col",     32'(dp_col), 32'd0);
        check("rs_pending", 32'(pending), 32'd0);
        check("rs_w",       32'(w_o == '0), 32'd1);
        check("rs_wt",      w_t_o, 32'h0);
        check("rs_a",       32'(a_o == '0), 32'd1);
        rst = 1'b0;
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        check("rs_shadow_zero", 32'(w_o == '0), 32'd1);
        check("rs_wt_shadow",   w_t_o, 32'h0);

        // Zero-size starts are ignored
        start_frame(16'd0, 16'd4);
        check("z_w0", 32'(busy), 32'd0);
        start_frame(16'd4, 16'd0);
        check("z_h0", 32'(busy), 32'd0);
        check("z_ready", 32'(pix_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
